mem_stage: RTL and testbench

//  Fourth pipeline stage. Consumes the EXE->MEM registers, performs data-memory loads/stores over a
//  req/ack port, formats load data, resolves branch/jump redirects and flags misaligned accesses.

---
 rtl/mem_stage_pkg.sv | 49 ++++
 rtl/mem_load_align.sv | 31 +++
 rtl/mem_stage.sv | 159 +++++++++++++++
 tb/tb_mem_stage.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: control-word layouts,
// funct3 access codes, access-size decode and FSM encoding.
package mem_stage_pkg;

    // EXE->MEM control word, MSB first: the field order is the bit map.
    typedef struct packed {
        logic       jump_r;   // [13]
        logic [2:0] funct3;   // [12:10]
        logic [4:0] rd;       // [9:5]
        logic       branch;   // [4]
        logic       wr_rf;    // [3]
        logic       store;    // [2]
        logic       load;     // [1]
        logic       jump;     // [0]
    } ctrl_mem_t;

    // MEM->WB control word.
    typedef struct packed {
        logic [2:0] funct3;   // [9:7]
        logic [4:0] rd;       // [6:2]
        logic       wr_rf;    // [1]
        logic       load;     // [0]
    } ctrl_wb_t;

    localparam int CTRL_MEM_W = $bits(ctrl_mem_t);
    localparam int CTRL_WB_W  = $bits(ctrl_wb_t);

    // Stores share the low three codes with the signed loads.
    localparam logic [2:0] F3_LB_SB = 3'b000;
    localparam logic [2:0] F3_LH_SH = 3'b001;
    localparam logic [2:0] F3_LW_SW = 3'b010;
    localparam logic [2:0] F3_LBU   = 3'b100;
    localparam logic [2:0] F3_LHU   = 3'b101;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    // Access width implied by funct3; unknown codes behave as word accesses.
    function automatic size_t access_size(input logic [2:0] funct3);
        case (funct3)
            F3_LB_SB, F3_LBU: return SZ_B;
            F3_LH_SH, F3_LHU: return SZ_H;
            F3_LW_SW:         return SZ_W;
            default:          return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data formatting: picks the addressed byte/half out of the read word
// and sign- or zero-extends it according to funct3.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and extension of the read word
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through
        // the case statement can leave it unassigned and infer a latch.
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        value    = rdata;
        case (funct3)
            F3_LB_SB: value = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:   value = {24'h0, byte_sel};
            F3_LH_SH: value = {{16{half_sel[15]}}, half_sel};
            F3_LHU:   value = {16'h0, half_sel};
            default:  value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory req/ack access with a one-entry request
// buffer, store lane steering, load formatting, branch/jump redirect and
// misalignment detection, registered MEM->WB bundle.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CTRL_MEM_W-1:0] control_registers_MEM,
    input  logic [SIZE-1:0]       ALU_result,
    input  logic [SIZE-1:0]       rs2_store_data_MEM,
    input  logic [SIZE-1:0]       immidiate_to_MEM,
    input  logic [SIZE-1:0]       PC_MEM,
    input  logic                  take_branch,
    input  logic [31:0]           dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [SIZE-1:0]       dmem_addr,
    output logic [31:0]           dmem_wdata,
    output logic [3:0]            dmem_be,
    output logic                  mem_stall,
    output logic                  misaligned_ldst_exception,
    output logic                  misaligned_jump_exception,
    output logic [SIZE-1:0]       jump_address,
    output logic                  pc_redirect,
    output logic [CTRL_WB_W-1:0]  control_registers_WB,
    output logic [SIZE-1:0]       ALU_result_to_WB
);

    ctrl_mem_t ctrl;
    state_t    state;
    logic      waiting;

    // Request buffer: holds the access while EXE feeds bubbles during a stall.
    logic [SIZE-1:0] buf_addr;
    logic [31:0]     buf_wdata;
    logic [3:0]      buf_be;
    logic            buf_we;
    ctrl_wb_t        buf_ctrl;

    ctrl_wb_t        wb_ctrl;
    logic [SIZE-1:0] wb_data;

    size_t           live_size;
    logic            misaligned_ldst;
    logic            live_access;
    logic [3:0]      live_be;
    logic [31:0]     live_wdata;
    ctrl_wb_t        live_wb;
    logic [SIZE-1:0] target;
    logic            taken;
    logic [SIZE-1:0] req_addr;
    logic [31:0]     load_value;

    assign ctrl    = ctrl_mem_t'(control_registers_MEM);
    assign waiting = (state == ST_WAIT);

    // Decode the live instruction: store lanes and alignment check
    always_comb begin
        live_size       = access_size(ctrl.funct3);
        live_be         = 4'b1111;
        live_wdata      = rs2_store_data_MEM[31:0];
        misaligned_ldst = 1'b0;
        case (live_size)
            SZ_B: begin
                live_be    = 4'b0001 << ALU_result[1:0];
                live_wdata = {4{rs2_store_data_MEM[7:0]}};
            end
            SZ_H: begin
                live_be         = ALU_result[1] ? 4'b1100 : 4'b0011;
                live_wdata      = {2{rs2_store_data_MEM[15:0]}};
                misaligned_ldst = ALU_result[0];
            end
            default: misaligned_ldst = (ALU_result[1:0] != 2'b00);
        endcase
        misaligned_ldst = misaligned_ldst & (ctrl.load | ctrl.store);
    end

    assign live_access = (ctrl.load | ctrl.store) & ~misaligned_ldst;
    assign live_wb     = '{funct3: ctrl.funct3, rd: ctrl.rd, wr_rf: ctrl.wr_rf, load: ctrl.load};

    // Redirect target; flags are suppressed while an access is outstanding.
    assign target       = ctrl.jump_r ? {ALU_result[SIZE-1:1], 1'b0} : PC_MEM + immidiate_to_MEM;
    assign taken        = ctrl.jump | ctrl.jump_r | (ctrl.branch & take_branch);
    assign jump_address = target;
    assign pc_redirect  = ~waiting & taken & (target[1:0] == 2'b00);
    assign misaligned_jump_exception = ~waiting & taken & (target[1:0] != 2'b00);
    assign misaligned_ldst_exception = ~waiting & misaligned_ldst;

    // Memory port: live inputs in IDLE, buffered request in WAIT.
    assign req_addr   = waiting ? buf_addr : ALU_result;
    assign dmem_req   = waiting | live_access;
    assign dmem_we    = waiting ? buf_we : ctrl.store;
    assign dmem_addr  = {req_addr[SIZE-1:2], 2'b00};
    assign dmem_wdata = waiting ? buf_wdata : live_wdata;
    assign dmem_be    = waiting ? buf_be : live_be;
    assign mem_stall  = waiting ? ~dmem_ack : (live_access & ~dmem_ack);

    mem_load_align u_load_align (
        .funct3  (waiting ? buf_ctrl.funct3 : ctrl.funct3),
        .addr_lo (req_addr[1:0]),
        .rdata   (dmem_rdata),
        .value   (load_value)
    );

    // FSM, request buffer capture and MEM->WB registers
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values,
        // independent of statement order.
        if (reset) begin
            state     <= ST_IDLE;
            buf_addr  <= '0;
            buf_wdata <= '0;
            buf_be    <= '0;
            buf_we    <= 1'b0;
            buf_ctrl  <= '0;
            wb_ctrl   <= '0;
            wb_data   <= '0;
        end else begin
            wb_ctrl <= '0;
            wb_data <= '0;
            case (state)
                ST_IDLE: begin
                    if (live_access && !dmem_ack) begin
                        state     <= ST_WAIT;
                        buf_addr  <= ALU_result;
                        buf_wdata <= live_wdata;
                        buf_be    <= live_be;
                        buf_we    <= ctrl.store;
                        buf_ctrl  <= live_wb;
                    end else if (!misaligned_ldst) begin
                        wb_ctrl <= live_wb;
                        if (ctrl.jump || ctrl.jump_r)
                            wb_data <= PC_MEM + SIZE'(4);
                        else if (ctrl.load)
                            wb_data <= SIZE'(load_value);
                        else
                            wb_data <= ALU_result;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack) begin
                        state   <= ST_IDLE;
                        wb_ctrl <= buf_ctrl;
                        wb_data <= buf_ctrl.load ? SIZE'(load_value) : buf_addr;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign control_registers_WB = wb_ctrl;
    assign ALU_result_to_WB     = wb_data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a transaction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] ctrl_mem;
    logic [31:0] alu, rs2, imm, pc;
    logic        take_branch;
    logic [31:0] rdata;
    logic        ack;

    logic        dmem_req, dmem_we, mem_stall;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        mis_ldst, mis_jump, pc_redirect;
    logic [31:0] jump_address, wb_data;
    logic [9:0]  wb_ctrl;

    mem_stage #(.SIZE(32)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .control_registers_MEM     (ctrl_mem),
        .ALU_result                (alu),
        .rs2_store_data_MEM        (rs2),
        .immidiate_to_MEM          (imm),
        .PC_MEM                    (pc),
        .take_branch               (take_branch),
        .dmem_rdata                (rdata),
        .dmem_ack                  (ack),
        .dmem_req                  (dmem_req),
        .dmem_we                   (dmem_we),
        .dmem_addr                 (dmem_addr),
        .dmem_wdata                (dmem_wdata),
        .dmem_be                   (dmem_be),
        .mem_stall                 (mem_stall),
        .misaligned_ldst_exception (mis_ldst),
        .misaligned_jump_exception (mis_jump),
        .jump_address              (jump_address),
        .pc_redirect               (pc_redirect),
        .control_registers_WB      (wb_ctrl),
        .ALU_result_to_WB          (wb_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        wr_rf;
        logic        load;
    } req_t;

    req_t        pend_q[$];
    logic        model_live = 1'b0;
    logic [9:0]  exp_wb_ctrl = 10'h0;
    logic [31:0] exp_wb_data = 32'h0;

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] d);
        logic [31:0] sh;
        sh = d >> (8 * lo);
        case (f3)
            3'd0:    return {{24{sh[7]}}, sh[7:0]};
            3'd4:    return {24'h0, sh[7:0]};
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd5:    return {16'h0, sh[15:0]};
            default: return d;
        endcase
    endfunction

    always @(negedge clk) begin : model
        logic        jr, br, wr, st, ld, j, taken, misal, access;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] target, e_wdata;
        logic [3:0]  e_be;
        int          sz;
        req_t        r;

        jr = ctrl_mem[13]; f3 = ctrl_mem[12:10]; rd = ctrl_mem[9:5]; br = ctrl_mem[4];
        wr = ctrl_mem[3];  st = ctrl_mem[2];     ld = ctrl_mem[1];   j  = ctrl_mem[0];
        sz      = size_of(f3);
        misal   = (ld | st) && ((sz == 2 && alu[0]) || (sz == 4 && alu[1:0] != 2'b00));
        access  = (ld | st) && !misal;
        e_be    = (sz == 1) ? (4'b0001 << alu[1:0]) : (sz == 2) ? (4'b0011 << alu[1:0]) : 4'b1111;
        e_wdata = (sz == 1) ? {4{rs2[7:0]}} : (sz == 2) ? {2{rs2[15:0]}} : rs2;
        target  = jr ? (alu & 32'hFFFF_FFFE) : pc + imm;
        taken   = j | jr | (br & take_branch);

        if (model_live) begin
            if (pend_q.size() != 0) begin
                check("m_req", 32'(dmem_req), 32'd1);
                check("m_stall", 32'(mem_stall), 32'(!ack));
                check("m_addr", dmem_addr, {pend_q[0].addr[31:2], 2'b00});
                check("m_we", 32'(dmem_we), 32'(pend_q[0].we));
                if (pend_q[0].we) begin
                    check("m_be", 32'(dmem_be), 32'(pend_q[0].be));
                    check("m_wdata", dmem_wdata, pend_q[0].wdata);
                end
                check("m_redirect", 32'(pc_redirect), 32'd0);
                check("m_mis_jump", 32'(mis_jump), 32'd0);
                check("m_mis_ldst", 32'(mis_ldst), 32'd0);
            end else begin
                check("m_req", 32'(dmem_req), 32'(access));
                check("m_stall", 32'(mem_stall), 32'(access && !ack));
                check("m_mis_ldst", 32'(mis_ldst), 32'(misal));
                check("m_redirect", 32'(pc_redirect), 32'(taken && target[1:0] == 2'b00));
                check("m_mis_jump", 32'(mis_jump), 32'(taken && target[1:0] != 2'b00));
                if (access) begin
                    check("m_addr", dmem_addr, {alu[31:2], 2'b00});
                    check("m_we", 32'(dmem_we), 32'(st));
                    if (st) begin
                        check("m_be", 32'(dmem_be), 32'(e_be));
                        check("m_wdata", dmem_wdata, e_wdata);
                    end
                end
            end
            check("m_jump_address", jump_address, target);
            check("m_wb_ctrl", 32'(wb_ctrl), 32'(exp_wb_ctrl));
            check("m_wb_data", wb_data, exp_wb_data);
        end

        // Advance the model across the coming rising edge.
        if (reset) begin
            pend_q.delete();
            exp_wb_ctrl = 10'h0;
            exp_wb_data = 32'h0;
            model_live  = 1'b1;
        end else if (pend_q.size() != 0) begin
            exp_wb_ctrl = 10'h0;
            exp_wb_data = 32'h0;
            if (ack) begin
                r = pend_q.pop_front();
                exp_wb_ctrl = {r.f3, r.rd, r.wr_rf, r.load};
                exp_wb_data = r.load ? load_fmt(r.f3, r.addr[1:0], rdata) : r.addr;
            end
        end else if (access && !ack) begin
            r.addr = alu; r.wdata = e_wdata; r.be = e_be; r.we = st;
            r.f3 = f3; r.rd = rd; r.wr_rf = wr; r.load = ld;
            pend_q.push_back(r);
            exp_wb_ctrl = 10'h0;
            exp_wb_data = 32'h0;
        end else if (misal) begin
            exp_wb_ctrl = 10'h0;
            exp_wb_data = 32'h0;
        end else begin
            exp_wb_ctrl = {f3, rd, wr, ld};
            exp_wb_data = (j | jr) ? pc + 32'd4 : ld ? load_fmt(f3, alu[1:0], rdata) : alu;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [13:0] ctl(input logic jr, input logic [2:0] f3, input logic [4:0] rd,
                                        input logic br, input logic wr, input logic st,
                                        input logic ld, input logic j);
        return {jr, f3, rd, br, wr, st, ld, j};
    endfunction

    task automatic set_in(input logic [13:0] c, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] im, input logic [31:0] p, input logic t,
                          input logic k, input logic [31:0] rdv);
        ctrl_mem = c; alu = a; rs2 = d; imm = im; pc = p; take_branch = t; ack = k; rdata = rdv;
    endtask

    task automatic bubble(input logic k, input logic [31:0] rdv);
        set_in(14'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, k, rdv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        reset = 1'b1;
        bubble(1'b0, 32'h0);
        tick(); tick();
        @(negedge clk);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_wb_ctrl", 32'(wb_ctrl), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        tick();
        reset = 1'b0;

        // SW, ack in the issue cycle
        set_in(ctl(1'b0, 3'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 32'h100, 32'hDEADBEEF,
               32'h0, 32'h10, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        check("sw_req", 32'(dmem_req), 32'd1);
        check("sw_we", 32'(dmem_we), 32'd1);
        check("sw_be", 32'(dmem_be), 32'hF);
        check("sw_wdata", dmem_wdata, 32'hDEADBEEF);
        check("sw_addr", dmem_addr, 32'h100);
        check("sw_stall", 32'(mem_stall), 32'd0);
        tick();
        bubble(1'b0, 32'h0);
        @(negedge clk);
        check("sw_wb_wr_rf", 32'(wb_ctrl[1]), 32'd0);
        check("sw_wb_ctrl", 32'(wb_ctrl), 32'h100);
        check("sw_wb_data", wb_data, 32'h100);
        tick();

        // LB from 0x103, ack three cycles later
        set_in(ctl(1'b0, 3'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 32'h103, 32'h0,
               32'h0, 32'h14, 1'b0, 1'b0, 32'h0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bubble(1'b1, 32'h80112233);
            else if (i > 0) bubble(1'b0, 32'h0);
            @(negedge clk);
            if (mem_stall) cnt++;
            if (i == 0) begin
                check("lb_be", 32'(dmem_be), 32'h8);
                check("lb_addr", dmem_addr, 32'h100);
                check("lb_we", 32'(dmem_we), 32'd0);
            end
            if (i == 1) check("lb_wait_wb_bubble", 32'(wb_ctrl), 32'd0);
            tick();
        end
        bubble(1'b0, 32'h0);
        @(negedge clk);
        check("lb_stall_cycles", cnt, 32'd3);
        check("lb_wb_ctrl", 32'(wb_ctrl), 32'h017);
        check("lb_wb_data", wb_data, 32'hFFFFFF80);
        tick();

        // SH to an odd address
        set_in(ctl(1'b0, 3'd1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 32'h101, 32'h5555,
               32'h0, 32'h18, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("sh_mis_exc", 32'(mis_ldst), 32'd1);
        check("sh_req", 32'(dmem_req), 32'd0);
        check("sh_stall", 32'(mem_stall), 32'd0);
        tick();
        bubble(1'b0, 32'h0);
        @(negedge clk);
        check("sh_wb_ctrl", 32'(wb_ctrl), 32'd0);
        tick();

        // JALR to a misaligned target, then JAL
        set_in(ctl(1'b1, 3'd0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 32'h207, 32'h0,
               32'h0, 32'h40, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("jalr_target", jump_address, 32'h206);
        check("jalr_mis_jump", 32'(mis_jump), 32'd1);
        check("jalr_redirect", 32'(pc_redirect), 32'd0);
        tick();
        set_in(ctl(1'b0, 3'd0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), 32'h0, 32'h0,
               32'h10, 32'h40, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("jal_target", jump_address, 32'h50);
        check("jal_redirect", 32'(pc_redirect), 32'd1);
        check("jal_mis_jump", 32'(mis_jump), 32'd0);
        tick();
        bubble(1'b0, 32'h0);
        @(negedge clk);
        check("jal_wb_data", wb_data, 32'h44);
        check("jal_wb_ctrl", 32'(wb_ctrl), 32'h006);
        tick();

        // Conditional branch not taken, then taken
        set_in(ctl(1'b0, 3'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 32'h0, 32'h0,
               32'h20, 32'h80, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("bnt_redirect", 32'(pc_redirect), 32'd0);
        tick();
        take_branch = 1'b1;
        @(negedge clk);
        check("bt_redirect", 32'(pc_redirect), 32'd1);
        check("bt_target", jump_address, 32'hA0);
        tick();

        // JAL target and link value wrap around
        set_in(ctl(1'b0, 3'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), 32'h0, 32'h0,
               32'h20, 32'hFFFFFFF0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("wrap_target", jump_address, 32'h10);
        tick();
        bubble(1'b0, 32'h0);
        @(negedge clk);
        check("wrap_wb_data", wb_data, 32'hFFFFFFF4);
        tick();

        // SB into lane 2, SH into the upper half
        set_in(ctl(1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 32'h102, 32'h123456AB,
               32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        check("sb_be", 32'(dmem_be), 32'h4);
        check("sb_wdata", dmem_wdata, 32'hABABABAB);
        check("sb_addr", dmem_addr, 32'h100);
        tick();
        set_in(ctl(1'b0, 3'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 32'h102, 32'h0000BEEF,
               32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        check("sh_hi_be", 32'(dmem_be), 32'hC);
        check("sh_hi_wdata", dmem_wdata, 32'hBEEFBEEF);
        tick();

        // LH and LHU from the upper half, same-cycle ack
        set_in(ctl(1'b0, 3'd1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 32'h102, 32'h0,
               32'h0, 32'h0, 1'b0, 1'b1, 32'h80017FFF);
        @(negedge clk);
        check("lh_stall", 32'(mem_stall), 32'd0);
        tick();
        set_in(ctl(1'b0, 3'd5, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 32'h102, 32'h0,
               32'h0, 32'h0, 1'b0, 1'b1, 32'h80017FFF);
        @(negedge clk);
        check("lh_wb_data", wb_data, 32'hFFFF8001);
        check("lh_wb_ctrl", 32'(wb_ctrl), 32'h09B);
        tick();
        set_in(ctl(1'b0, 3'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 32'h1234, 32'h0,
               32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        check("lhu_wb_data", wb_data, 32'h00008001);
        tick();
        bubble(1'b0, 32'h0);
        @(negedge clk);
        check("alu_wb_data", wb_data, 32'h1234);
        tick();

        // Reset while waiting on an access, ack arrives afterwards
        set_in(ctl(1'b0, 3'd2, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 32'h200, 32'h0,
               32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("rw_issue_stall", 32'(mem_stall), 32'd1);
        tick();
        bubble(1'b0, 32'h0);
        @(negedge clk);
        check("rw_wait_req", 32'(dmem_req), 32'd1);
        check("rw_wait_addr", dmem_addr, 32'h200);
        check("rw_wait_stall", 32'(mem_stall), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bubble(1'b1, 32'hCAFEF00D);
        @(negedge clk);
        check("rw_after_req", 32'(dmem_req), 32'd0);
        check("rw_after_stall", 32'(mem_stall), 32'd0);
        tick();
        bubble(1'b0, 32'h0);
        @(negedge clk);
        check("rw_late_ack_wb_ctrl", 32'(wb_ctrl), 32'd0);
        check("rw_late_ack_wb_data", wb_data, 32'd0);
        tick();

        // Back-to-back LW/LW, one cycle of ack latency each
        cnt = 0;
        set_in(ctl(1'b0, 3'd2, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 32'h300, 32'h0,
               32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        if (mem_stall) cnt++;
        tick();
        bubble(1'b1, 32'h11111111);
        @(negedge clk);
        if (mem_stall) cnt++;
        tick();
        set_in(ctl(1'b0, 3'd2, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 32'h304, 32'h0,
               32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        if (mem_stall) cnt++;
        check("b2b_wb1_ctrl", 32'(wb_ctrl), 32'h11F);
        check("b2b_wb1_data", wb_data, 32'h11111111);
        tick();
        bubble(1'b1, 32'h22222222);
        @(negedge clk);
        if (mem_stall) cnt++;
        tick();
        bubble(1'b0, 32'h0);
        @(negedge clk);
        check("b2b_stall_cycles", cnt, 32'd2);
        check("b2b_wb2_ctrl", 32'(wb_ctrl), 32'h123);
        check("b2b_wb2_data", wb_data, 32'h22222222);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
